// File: rtl/packet_router_rr.sv
// Round-robin packet router: classifies words into per-path FIFOs and drains them to one registered output.
// Drop counters exist only when PKT_ROUTER_DROP_CNT_EN is defined; otherwise both counter ports read 0.
module packet_router_rr #(
    parameter int PATH_COUNT  = 4,
    parameter int DATA_WIDTH  = 64,
    parameter int FIFO_DEPTH  = 8,
    parameter int MATCH_WIDTH = 4
) (
    input  logic                        iClk,
    input  logic                        iRstN,
    input  logic                        iPktValid,
    input  logic [DATA_WIDTH-1:0]       iPktData,
    input  logic [PATH_COUNT-1:0][31:0] iRegMatchCriteria,
    input  logic                        iOutReady,
    output logic [DATA_WIDTH-1:0]       oData,
    output logic [PATH_COUNT-1:0]       oDataVld,
    output logic [PATH_COUNT-1:0]       oFifoFull,
    output logic [31:0]                 oDropNoMatch,
    output logic [31:0]                 oDropFull
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = $clog2(PATH_COUNT);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0]  mem    [PATH_COUNT][FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr [PATH_COUNT];
    logic [PTR_W-1:0]       rd_ptr [PATH_COUNT];
    logic [CNT_W-1:0]       count  [PATH_COUNT];
    logic [IDX_W-1:0]       last_grant;

    logic [MATCH_WIDTH-1:0] pkt_field;
    logic                   hit_any;
    logic [IDX_W-1:0]       hit_idx;
    logic                   target_full;
    logic [PATH_COUNT-1:0]  wr_en;
    logic [PATH_COUNT-1:0]  rd_en;
    logic                   out_load;
    logic                   grant_vld;
    logic [IDX_W-1:0]       grant_idx;
    logic [PATH_COUNT-1:0]  grant_onehot;
    logic [IDX_W-1:0]       cand;
    int                     scan;

    assign pkt_field   = iPktData[DATA_WIDTH-1 -: MATCH_WIDTH];
    assign out_load    = (oDataVld == '0) || iOutReady;
    assign target_full = hit_any && (count[hit_idx] == DEPTH_CNT);

    // Descending scan so the lowest matching path wins on multiple hits.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = PATH_COUNT - 1; i >= 0; i--) begin
            if (iPktValid && (pkt_field == iRegMatchCriteria[i][31 -: MATCH_WIDTH])) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        grant_vld    = 1'b0;
        grant_idx    = '0;
        grant_onehot = '0;
        scan         = 0;
        cand         = '0;
        for (int k = 1; k <= PATH_COUNT; k++) begin
            scan = int'(last_grant) + k;
            if (scan >= PATH_COUNT) begin
                scan = scan - PATH_COUNT;
            end
            cand = IDX_W'(scan);
            if (!grant_vld && (count[cand] != '0)) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        if (grant_vld) begin
            grant_onehot[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        wr_en     = '0;
        rd_en     = '0;
        oFifoFull = '0;
        for (int i = 0; i < PATH_COUNT; i++) begin
            wr_en[i]     = hit_any && !target_full && (hit_idx == IDX_W'(i));
            rd_en[i]     = out_load && grant_vld && (grant_idx == IDX_W'(i));
            oFifoFull[i] = (count[i] == DEPTH_CNT);
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            for (int i = 0; i < PATH_COUNT; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < PATH_COUNT; i++) begin
                if (wr_en[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                end
                if (rd_en[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                end
                count[i] <= count[i] + CNT_W'(wr_en[i]) - CNT_W'(rd_en[i]);
            end
        end
    end

    // Storage needs no reset: occupancy is governed entirely by the pointers and counts.
    always_ff @(posedge iClk) begin
        for (int i = 0; i < PATH_COUNT; i++) begin
            if (wr_en[i]) begin
                mem[i][wr_ptr[i]] <= iPktData;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            oData      <= '0;
            oDataVld   <= '0;
            last_grant <= IDX_W'(PATH_COUNT - 1);
        end else if (out_load) begin
            oDataVld <= grant_onehot;
            if (grant_vld) begin
                oData      <= mem[grant_idx][rd_ptr[grant_idx]];
                last_grant <= grant_idx;
            end
        end
    end

`ifdef PKT_ROUTER_DROP_CNT_EN
    logic drop_nomatch;
    logic drop_full;

    assign drop_nomatch = iPktValid && !hit_any;
    assign drop_full    = target_full;

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            oDropNoMatch <= '0;
            oDropFull    <= '0;
        end else begin
            if (drop_nomatch && (oDropNoMatch != '1)) begin
                oDropNoMatch <= oDropNoMatch + 32'd1;
            end
            if (drop_full && (oDropFull != '1)) begin
                oDropFull <= oDropFull + 32'd1;
            end
        end
    end
`else
    assign oDropNoMatch = '0;
    assign oDropFull    = '0;
`endif

endmodule

// File: tb/tb_packet_router_rr.sv
// Self-checking bench for packet_router_rr: queue-based reference model checked every cycle plus directed literal checks.
// Drop-counter expectations follow PKT_ROUTER_DROP_CNT_EN.
module tb_packet_router_rr;
    localparam int P  = 4;
    localparam int DW = 64;
    localparam int D  = 8;
    localparam int MW = 4;
`ifdef PKT_ROUTER_DROP_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic                iClk;
    logic                iRstN;
    logic                iPktValid;
    logic [DW-1:0]       iPktData;
    logic [P-1:0][31:0]  iRegMatchCriteria;
    logic                iOutReady;
    logic [DW-1:0]       oData;
    logic [P-1:0]        oDataVld;
    logic [P-1:0]        oFifoFull;
    logic [31:0]         oDropNoMatch;
    logic [31:0]         oDropFull;

    int checks = 0;
    int errors = 0;

    packet_router_rr #(
        .PATH_COUNT(P), .DATA_WIDTH(DW), .FIFO_DEPTH(D), .MATCH_WIDTH(MW)
    ) dut (
        .iClk(iClk), .iRstN(iRstN), .iPktValid(iPktValid), .iPktData(iPktData),
        .iRegMatchCriteria(iRegMatchCriteria), .iOutReady(iOutReady),
        .oData(oData), .oDataVld(oDataVld), .oFifoFull(oFifoFull),
        .oDropNoMatch(oDropNoMatch), .oDropFull(oDropFull)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Reference model: one queue per path, the word in the output slot, and the last granted path.
    logic [DW-1:0] mq [P][$];
    int            m_vld;
    logic [DW-1:0] m_data;
    int            m_last;
    int            m_nm;
    int            m_fl;

    always @(posedge iClk or negedge iRstN) begin : model
        int g;
        int t;
        int pp;
        bit ld;
        bit push;
        if (!iRstN) begin
            for (int i = 0; i < P; i++) mq[i].delete();
            m_vld  = -1;
            m_data = '0;
            m_last = P - 1;
            m_nm   = 0;
            m_fl   = 0;
        end else begin
            ld   = (m_vld < 0) || iOutReady;
            g    = -1;
            push = 1'b0;
            t    = -1;
            if (ld) begin
                for (int k = 1; k <= P; k++) begin
                    pp = (m_last + k) % P;
                    if (g < 0 && mq[pp].size() > 0) g = pp;
                end
            end
            if (iPktValid) begin
                for (int i = 0; i < P; i++) begin
                    if (t < 0 && iPktData[DW-1 -: MW] == iRegMatchCriteria[i][31 -: MW]) t = i;
                end
                if (t < 0) m_nm++;
                else if (mq[t].size() == D) m_fl++;
                else push = 1'b1;
            end
            if (ld) begin
                if (g >= 0) begin
                    m_data = mq[g].pop_front();
                    m_vld  = g;
                    m_last = g;
                end else begin
                    m_vld = -1;
                end
            end
            if (push) mq[t].push_back(iPktData);
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge iClk) begin : compare
        logic [P-1:0] ev;
        logic [P-1:0] ef;
        ev = (m_vld < 0) ? '0 : (P'(1) << m_vld);
        for (int i = 0; i < P; i++) ef[i] = (mq[i].size() == D);
        checkOutput("model_vld", 64'(oDataVld), 64'(ev));
        if (m_vld >= 0) checkOutput("model_data", oData, m_data);
        checkOutput("model_full", 64'(oFifoFull), 64'(ef));
        checkOutput("model_nomatch", 64'(oDropNoMatch), CNT_EN ? 64'(m_nm) : 64'd0);
        checkOutput("model_dropfull", 64'(oDropFull), CNT_EN ? 64'(m_fl) : 64'd0);
    end

    // Called at a negedge; presents one word for one cycle and returns at the next negedge.
    task automatic applyStimulus(input logic [DW-1:0] d);
        iPktValid = 1'b1;
        iPktData  = d;
        @(negedge iClk);
        iPktValid = 1'b0;
        iPktData  = '0;
    endtask

    task automatic doReset();
        iPktValid = 1'b0;
        iRstN     = 1'b0;
        @(negedge iClk);
        @(negedge iClk);
        iRstN = 1'b1;
    endtask

    task automatic defaultCriteria();
        iRegMatchCriteria[0] = 32'h1000_0000;
        iRegMatchCriteria[1] = 32'h2000_0000;
        iRegMatchCriteria[2] = 32'h3000_0000;
        iRegMatchCriteria[3] = 32'h4000_0000;
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stim
        logic [P-1:0]  vseq [$];
        logic [DW-1:0] dseq [$];
        logic [DW-1:0] w;
        iRstN     = 1'b0;
        iPktValid = 1'b0;
        iPktData  = '0;
        iOutReady = 1'b1;
        defaultCriteria();
        @(negedge iClk);
        doReset();
        checkOutput("reset_vld", 64'(oDataVld), 64'd0);
        checkOutput("reset_data", oData, 64'd0);
        checkOutput("reset_full", 64'(oFifoFull), 64'd0);

        // Single word to path1: visible two edges after it is presented, for one cycle.
        applyStimulus(64'h2000_0000_0000_00AA);
        @(negedge iClk);
        checkOutput("single_vld", 64'(oDataVld), 64'b0010);
        checkOutput("single_data", oData, 64'h2000_0000_0000_00AA);
        @(negedge iClk);
        checkOutput("single_gone", 64'(oDataVld), 64'd0);

        // Alternating paths 0 and 2 under stall, then release.
        doReset();
        iOutReady = 1'b0;
        applyStimulus(64'h1000_0000_0000_0001);
        applyStimulus(64'h3000_0000_0000_0002);
        applyStimulus(64'h1000_0000_0000_0003);
        applyStimulus(64'h3000_0000_0000_0004);
        for (int c = 0; c < 3; c++) begin
            checkOutput("stall_vld", 64'(oDataVld), 64'b0001);
            checkOutput("stall_data", oData, 64'h1000_0000_0000_0001);
            @(negedge iClk);
        end
        iOutReady = 1'b1;
        vseq.delete();
        for (int c = 0; c < 10; c++) begin
            if (oDataVld != '0) vseq.push_back(oDataVld);
            @(negedge iClk);
        end
        checkOutput("rr_count", 64'(vseq.size()), 64'd4);
        if (vseq.size() == 4) begin
            checkOutput("rr_order0", 64'(vseq[0]), 64'b0001);
            checkOutput("rr_order1", 64'(vseq[1]), 64'b0100);
            checkOutput("rr_order2", 64'(vseq[2]), 64'b0001);
            checkOutput("rr_order3", 64'(vseq[3]), 64'b0100);
        end

        // Path0 word parks in the output slot, path1 fills exactly, three more overflow.
        doReset();
        iOutReady = 1'b0;
        applyStimulus(64'h1000_0000_0000_00F0);
        for (int i = 0; i < 11; i++) applyStimulus(64'h2000_0000_0000_0010 + 64'(i));
        checkOutput("fill_full", 64'(oFifoFull), 64'b0010);
        checkOutput("fill_dropfull", 64'(oDropFull), CNT_EN ? 64'd3 : 64'd0);
        iOutReady = 1'b1;
        dseq.delete();
        for (int c = 0; c < 16; c++) begin
            if (oDataVld != '0) dseq.push_back(oData);
            @(negedge iClk);
        end
        checkOutput("fill_count", 64'(dseq.size()), 64'd9);
        if (dseq.size() == 9) begin
            checkOutput("fill_first", dseq[0], 64'h1000_0000_0000_00F0);
            for (int i = 0; i < 8; i++) begin
                w = 64'h2000_0000_0000_0010 + 64'(i);
                checkOutput("fill_order", dseq[i+1], w);
            end
        end

        // No-match words are dropped and never surface.
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(64'hF000_0000_0000_0000 + 64'(i));
        @(negedge iClk);
        checkOutput("nomatch_vld", 64'(oDataVld), 64'd0);
        checkOutput("nomatch_cnt", 64'(oDropNoMatch), CNT_EN ? 64'd5 : 64'd0);

        // Duplicate criteria: the lowest path takes the word.
        doReset();
        iRegMatchCriteria[0] = 32'h5000_0000;
        iRegMatchCriteria[3] = 32'h5000_0000;
        applyStimulus(64'h5000_0000_0000_0077);
        @(negedge iClk);
        checkOutput("dup_vld", 64'(oDataVld), 64'b0001);
        checkOutput("dup_data", oData, 64'h5000_0000_0000_0077);
        @(negedge iClk);
        checkOutput("dup_none", 64'(oDataVld), 64'd0);
        defaultCriteria();

        // Asynchronous reset during a drain of path3.
        doReset();
        iOutReady = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(64'h4000_0000_0000_0030 + 64'(i));
        iOutReady = 1'b1;
        @(posedge iClk);
        #2;
        iRstN = 1'b0;
        #1;
        checkOutput("async_vld", 64'(oDataVld), 64'd0);
        checkOutput("async_full", 64'(oFifoFull), 64'd0);
        @(negedge iClk);
        @(negedge iClk);
        iRstN = 1'b1;
        for (int c = 0; c < 4; c++) @(negedge iClk);
        checkOutput("async_nostale", 64'(oDataVld), 64'd0);
        applyStimulus(64'h1000_0000_0000_0055);
        @(negedge iClk);
        checkOutput("async_next_vld", 64'(oDataVld), 64'b0001);
        checkOutput("async_next_data", oData, 64'h1000_0000_0000_0055);
        @(negedge iClk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
